compressor: RTL and testbench
=============================

// Module: compressor
// PURPOSE
//  Multi-operand compressor tree (25 columns x 25 rows) reducing a square dot array to one 30-bit binary sum.
//  Column srcN carries 25 bits, each of weight 2^N.
//  The result is the weighted population count: SUM over N of popcount(srcN) << N.
//  The block sits behind a bit-serial shift-register front end; outputs are per-bit columns dst0..dst29.
// PARAMETERS
//  (fixed localparams; the port list is flat so they are not overridable)
//  N_COLS  25  number of input columns (src0..src24)
//  HEIGHT  25  bits per column (width of each srcN)
//  OUT_W   30  result width; ceil(log2(25*(2^25-1)+1)) = 30
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rst             in   1   synchronous, active-high reset
//  src0..src24     in   25  column N: 25 bits of weight 2^N; bit order within a column is irrelevant
//  dst0..dst29     out  1   result bit k (weight 2^k) of the registered sum
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: when rst=1 at a posedge, all dst* = 0 after that edge. The combinational tree has no state.
//  - Latency: exactly 1 cycle.
//    - Inputs sampled at posedge t drive dst* after posedge t.
//    - New inputs may be accepted every cycle; there is no handshake.
//  - dst0..dst29 = sum over N=0..24, i=0..24 of srcN[i] * 2^N.
//    - Exact, never saturates or wraps.
//    - Maximum value: 25*(2^25-1) = 838860775 = 0x31FFFFE7, which fits in 30 bits.
//  - Tree: cascade of 3:2 counters (full adders) and 2:2 counters (half adders), applied column by column.
//    - Each counter's sum stays in column N; its carry moves to column N+1.
//    - Reduce until every column height is <= 2.
//    - Finish with a 30-bit ripple/carry-propagate adder of the two remaining rows.
//    - Any carry out of bit 29 is provably 0 and is dropped.
//  - Simultaneous rst and input change: rst wins; the next non-reset edge loads the sum of the inputs current at that edge.
//  - Outputs before the first clock edge: 0 (output register initialised to 0).
//  - Correctness is the arithmetic identity above; tree shape and counter count are not checked.
// STRUCTURE
//  - Shared package cmp_pkg: N_COLS, HEIGHT, OUT_W constants.
//  - One sub-module: full_adder (a,b,cin -> s,cout). Half adders use full_adder with cin=0 or inline logic.
//  - Top level: generate-based column reduction, final CPA, then the output register with sync reset.
// TESTING
//  1. rst=1 for 2 cycles with all src = 25'h1FFFFFF -> dst = 0 while reset is held.
//  2. All src = 0 -> dst = 0 one cycle later.
//  3. All src = 25'h1FFFFFF -> dst = 0x31FFFFE7 (838860775) one cycle later.
//  4. Single-column weights, each -> response one cycle later:
//     - src0 = 25'h1FFFFFF, others 0 -> dst = 25 (0x19).
//     - src24 = 25'h1FFFFFF, others 0 -> dst = 0x19000000.
//     - only src3[7] = 1 -> dst = 8.
//  5. Back-to-back stream of 1000 random column vectors, one per cycle -> every cycle dst equals the reference
//     weighted popcount of the previous cycle's inputs.
//  6. Assert rst for 1 cycle mid-stream -> dst = 0 for exactly that cycle, then tracks the inputs again with 1-cycle latency.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared sizes for the compressor tree and elaboration-time column height model
package cmp_pkg;
  localparam int N_COLS = 25;
  localparam int HEIGHT = 25;
  localparam int OUT_W = 30;
  localparam int N_STG = 12;
  // Height of column c entering stage s: each stage packs triples into full adders, leftovers pass through
  function automatic int col_h(int s, int c);
    int h [OUT_W];
    int n [OUT_W];
    for (int k = 0; k < OUT_W; k++) h[k] = k < N_COLS ? HEIGHT : 0;
    for (int t = 0; t < s; t++) begin
      for (int k = 0; k < OUT_W; k++) n[k] = h[k] / 3 + h[k] % 3 + (k > 0 ? h[k-1] / 3 : 0);
      h = n;
    end
    return h[c];
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: 3:2 counter
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/compressor.sv
// compressor: 25x25 weighted popcount via 3:2 counter tree, ripple CPA and 1-cycle output register
module compressor
  import cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [HEIGHT-1:0] src0, src1, src2, src3, src4, src5, src6, src7, src8, src9,
  input  logic [HEIGHT-1:0] src10, src11, src12, src13, src14, src15, src16, src17, src18, src19,
  input  logic [HEIGHT-1:0] src20, src21, src22, src23, src24,
  output logic dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9,
  output logic dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19,
  output logic dst20, dst21, dst22, dst23, dst24, dst25, dst26, dst27, dst28, dst29
);
  logic [HEIGHT-1:0] src [N_COLS];
  logic [HEIGHT-1:0] col [N_STG+1][OUT_W];
  logic [HEIGHT-1:0] cy [N_STG][OUT_W];
  logic [OUT_W-1:0] ra, rb, sum;
  logic [OUT_W:0] k;
  logic [OUT_W-1:0] q = '0;
  assign src = '{src0, src1, src2, src3, src4, src5, src6, src7, src8, src9, src10, src11, src12,
                 src13, src14, src15, src16, src17, src18, src19, src20, src21, src22, src23, src24};
  for (genvar c = 0; c < OUT_W; c++) begin : g_in
    if (c < N_COLS) begin : g_src
      assign col[0][c] = src[c];
    end else begin : g_zero
      assign col[0][c] = '0;
    end
  end
  // Next column: own sums at the bottom, untouched leftovers above them, carries from column c-1 on top
  for (genvar s = 0; s < N_STG; s++) begin : g_stg
    for (genvar c = 0; c < OUT_W; c++) begin : g_col
      localparam int H = col_h(s, c);
      localparam int F = H / 3;
      localparam int R = H % 3;
      localparam logic [HEIGHT-1:0] MR = HEIGHT'((1 << R) - 1);
      logic [HEIGHT-1:0] sm;
      for (genvar i = 0; i < HEIGHT; i++) begin : g_fa
        if (i < F) begin : g_cnt
          full_adder u_fa (.a(col[s][c][3*i]), .b(col[s][c][3*i+1]), .cin(col[s][c][3*i+2]),
                           .s(sm[i]), .cout(cy[s][c][i]));
        end else begin : g_pad
          assign sm[i] = 1'b0;
          assign cy[s][c][i] = 1'b0;
        end
      end
      if (c > 0) begin : g_carry
        assign col[s+1][c] = sm | (((col[s][c] >> (3*F)) & MR) << F) | (cy[s][c-1] << (F+R));
      end else begin : g_first
        assign col[s+1][c] = sm | (((col[s][c] >> (3*F)) & MR) << F);
      end
    end
  end
  assign k[0] = 1'b0;
  for (genvar c = 0; c < OUT_W; c++) begin : g_cpa
    assign ra[c] = col[N_STG][c][0];
    assign rb[c] = col[N_STG][c][1];
    full_adder u_cpa (.a(ra[c]), .b(rb[c]), .cin(k[c]), .s(sum[c]), .cout(k[c+1]));
  end
  always_ff @(posedge clk)
    q <= rst ? '0 : sum;
  assign {dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22, dst21, dst20,
          dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10,
          dst9, dst8, dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0} = q;
endmodule

// File: tb/tb_compressor.sv
// tb_compressor: directed and random checks of the registered weighted popcount
module tb_compressor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [24:0] s [25];
  logic [29:0] d;
  int checks = 0;
  int errs = 0;
  always #5 clk = ~clk;
  compressor dut (
    .clk(clk), .rst(rst),
    .src0(s[0]), .src1(s[1]), .src2(s[2]), .src3(s[3]), .src4(s[4]), .src5(s[5]), .src6(s[6]),
    .src7(s[7]), .src8(s[8]), .src9(s[9]), .src10(s[10]), .src11(s[11]), .src12(s[12]),
    .src13(s[13]), .src14(s[14]), .src15(s[15]), .src16(s[16]), .src17(s[17]), .src18(s[18]),
    .src19(s[19]), .src20(s[20]), .src21(s[21]), .src22(s[22]), .src23(s[23]), .src24(s[24]),
    .dst0(d[0]), .dst1(d[1]), .dst2(d[2]), .dst3(d[3]), .dst4(d[4]), .dst5(d[5]), .dst6(d[6]),
    .dst7(d[7]), .dst8(d[8]), .dst9(d[9]), .dst10(d[10]), .dst11(d[11]), .dst12(d[12]),
    .dst13(d[13]), .dst14(d[14]), .dst15(d[15]), .dst16(d[16]), .dst17(d[17]), .dst18(d[18]),
    .dst19(d[19]), .dst20(d[20]), .dst21(d[21]), .dst22(d[22]), .dst23(d[23]), .dst24(d[24]),
    .dst25(d[25]), .dst26(d[26]), .dst27(d[27]), .dst28(d[28]), .dst29(d[29])
  );
  function automatic logic [29:0] ref_sum();
    longint acc = 0;
    for (int n = 0; n < 25; n++) acc += longint'($countones(s[n])) << n;
    return acc[29:0];
  endfunction
  task automatic fill(input logic [24:0] v);
    for (int n = 0; n < 25; n++) s[n] = v;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [29:0] exp);
    checks++;
    assert (d === exp) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, d, exp);
    end
  endtask
  initial begin
    logic [29:0] exp;
    fill(25'h1FFFFFF);
    #1;
    chk("init", 30'h0);
    tick();
    chk("rst_1", 30'h0);
    tick();
    chk("rst_2", 30'h0);
    rst = 1'b0;
    fill(25'h0);
    tick();
    chk("all_zero", 30'h0);
    fill(25'h1FFFFFF);
    tick();
    chk("all_ones", 30'h31FFFFE7);
    fill(25'h0);
    s[0] = 25'h1FFFFFF;
    tick();
    chk("col0_full", 30'h19);
    fill(25'h0);
    s[24] = 25'h1FFFFFF;
    tick();
    chk("col24_full", 30'h19000000);
    fill(25'h0);
    s[3][7] = 1'b1;
    tick();
    chk("src3_bit7", 30'h8);
    for (int t = 0; t < 1000; t++) begin
      for (int n = 0; n < 25; n++) s[n] = 25'($urandom);
      rst = (t == 500);
      exp = rst ? 30'h0 : ref_sum();
      tick();
      chk(rst ? "mid_rst" : "stream", exp);
    end
    rst = 1'b0;
    fill(25'h0);
    s[1] = 25'h0000003;
    tick();
    chk("post_stream", 30'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
